ulpi_rx_packetizer: RTL and testbench

Receive-side front end between the ULPI PHY pins and the USB protocol state machine. Tracks bus ownership via DIR/NXT and separates RXCMD status bytes from packet data bytes. Frames each received USB packet as a byte stream with start and end markers, and decodes the PID. Validates PID, length and CRC5/CRC16, so the protocol FSM consumes whole, checked packets instead of sampling raw `data` byte-by-byte.

---
 rtl/usb_pkg.sv | 56 +++++
 rtl/usb_crc_byte.sv | 29 ++
 rtl/ulpi_rx_packetizer.sv | 256 +++++++++++++++++++++++++
 tb/tb_ulpi_rx_packetizer.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/usb_pkg.sv
// Shared USB receive constants: PIDs, RXCMD layout, packet error codes and CRC parameters.
package usb_pkg;

  localparam int unsigned BYTE_W = 8;
  localparam int unsigned PID_W  = 4;

  localparam logic [PID_W-1:0] PID_OUT   = 4'h1;
  localparam logic [PID_W-1:0] PID_IN    = 4'h9;
  localparam logic [PID_W-1:0] PID_SOF   = 4'h5;
  localparam logic [PID_W-1:0] PID_SETUP = 4'hD;
  localparam logic [PID_W-1:0] PID_DATA0 = 4'h3;
  localparam logic [PID_W-1:0] PID_DATA1 = 4'hB;
  localparam logic [PID_W-1:0] PID_DATA2 = 4'h7;
  localparam logic [PID_W-1:0] PID_MDATA = 4'hF;
  localparam logic [PID_W-1:0] PID_ACK   = 4'h2;
  localparam logic [PID_W-1:0] PID_NAK   = 4'hA;
  localparam logic [PID_W-1:0] PID_STALL = 4'hE;
  localparam logic [PID_W-1:0] PID_NYET  = 4'h6;

  localparam int unsigned RXCMD_LS_LSB   = 0;
  localparam int unsigned RXCMD_VBUS_LSB = 2;
  localparam int unsigned RXCMD_EV_LSB   = 4;

  localparam logic [1:0] RXEV_INACTIVE = 2'b00;
  localparam logic [1:0] RXEV_ACTIVE   = 2'b01;
  localparam logic [1:0] RXEV_ERROR    = 2'b11;

  typedef enum logic [2:0] {
    ERR_NONE  = 3'd0,
    ERR_PID   = 3'd1,
    ERR_CRC   = 3'd2,
    ERR_LEN   = 3'd3,
    ERR_RXERR = 3'd4,
    ERR_OVF   = 3'd5
  } pkt_err_e;

  localparam logic [4:0]  CRC5_POLY      = 5'h05;
  localparam logic [4:0]  CRC5_INIT      = 5'h1F;
  localparam logic [4:0]  CRC5_RESIDUE   = 5'h0C;
  localparam logic [15:0] CRC16_POLY     = 16'h8005;
  localparam logic [15:0] CRC16_INIT     = 16'hFFFF;
  localparam logic [15:0] CRC16_RESIDUE  = 16'h800D;

  function automatic logic is_token(input logic [PID_W-1:0] p);
    return (p == PID_OUT) || (p == PID_IN) || (p == PID_SOF) || (p == PID_SETUP);
  endfunction

  function automatic logic is_data(input logic [PID_W-1:0] p);
    return (p == PID_DATA0) || (p == PID_DATA1) || (p == PID_DATA2) || (p == PID_MDATA);
  endfunction

  function automatic logic is_hshk(input logic [PID_W-1:0] p);
    return (p == PID_ACK) || (p == PID_NAK) || (p == PID_STALL) || (p == PID_NYET);
  endfunction

endpackage

// File: rtl/usb_crc_byte.sv
// One-byte combinational update of the USB CRC5 and CRC16 registers, bits taken LSB-first.
module usb_crc_byte
  import usb_pkg::*;
(
  input  logic [BYTE_W-1:0] data_i,
  input  logic [4:0]        crc5_i,
  input  logic [15:0]       crc16_i,
  output logic [4:0]        crc5_o,
  output logic [15:0]       crc16_o
);

  function automatic logic [4:0] crc5_bit(input logic [4:0] c, input logic b);
    return {c[3:0], 1'b0} ^ ((c[4] ^ b) ? CRC5_POLY : 5'h00);
  endfunction

  function automatic logic [15:0] crc16_bit(input logic [15:0] c, input logic b);
    return {c[14:0], 1'b0} ^ ((c[15] ^ b) ? CRC16_POLY : 16'h0000);
  endfunction

  always_comb begin
    crc5_o  = crc5_i;
    crc16_o = crc16_i;
    for (int i = 0; i < int'(BYTE_W); i++) begin
      crc5_o  = crc5_bit(crc5_o, data_i[i]);
      crc16_o = crc16_bit(crc16_o, data_i[i]);
    end
  end

endmodule

// File: rtl/ulpi_rx_packetizer.sv
// ULPI receive front end: tracks bus ownership, splits RXCMD from packet bytes,
// frames packets with sop/eop and reports PID, length and CRC status per packet.
module ulpi_rx_packetizer
  import usb_pkg::*;
#(
  parameter int unsigned MAX_BYTES = 67
) (
  input  logic              CLKOUT,
  input  logic              RESET,
  input  logic              DIR,
  input  logic              NXT,
  input  logic [BYTE_W-1:0] ulpi_din,
  output logic              rx_valid,
  output logic [BYTE_W-1:0] rx_data,
  output logic              rx_sop,
  output logic              rx_eop,
  output logic              pkt_done,
  output logic              pkt_ok,
  output logic [2:0]        pkt_err,
  output logic [PID_W-1:0]  pkt_pid,
  output logic [6:0]        pkt_len,
  output logic [10:0]       tok_field,
  output logic [1:0]        linestate,
  output logic [1:0]        vbus_state
);

  localparam int unsigned     CNT_W   = 7;
  localparam logic [CNT_W-1:0] CNT_SAT = '1;
  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_BYTES);

  typedef enum logic [2:0] {
    ST_IDLE, ST_TURN_IN, ST_RX_CMD, ST_RX_PID, ST_RX_BODY, ST_TURN_OUT
  } state_e;

  state_e            st_q, st_d;
  logic [BYTE_W-1:0] hold_q, hold_d, pid_q, pid_d, b1_q, b1_d, rx_data_q, rx_data_d;
  logic              hold_vld_q, hold_vld_d, hold_sop_q, hold_sop_d;
  logic [2:0]        b2_q, b2_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d, pkt_len_q, pkt_len_d;
  logic [4:0]        crc5_q, crc5_d, crc5_nxt;
  logic [15:0]       crc16_q, crc16_d, crc16_nxt;
  logic              rxerr_q, rxerr_d, ovf_q, ovf_d;
  logic              rx_valid_q, rx_valid_d, rx_sop_q, rx_sop_d, rx_eop_q, rx_eop_d;
  logic              pkt_done_q, pkt_done_d, pkt_ok_q, pkt_ok_d;
  logic [2:0]        pkt_err_q, pkt_err_d;
  logic [PID_W-1:0]  pkt_pid_q, pkt_pid_d;
  logic [10:0]       tok_q, tok_d;
  logic [1:0]        ls_q, ls_d, vbus_q, vbus_d;

  logic       is_cmd, is_byte, in_pkt, take_pid, pkt_end;
  logic [1:0] rx_ev;
  logic       pid_bad, len_bad, crc_bad;
  pkt_err_e   err_c;

  assign is_cmd   = DIR && !NXT;
  assign is_byte  = DIR && NXT;
  assign rx_ev    = ulpi_din[RXCMD_EV_LSB +: 2];
  assign in_pkt   = (st_q == ST_RX_PID) || (st_q == ST_RX_BODY);
  assign take_pid = is_byte && ((st_q == ST_RX_CMD) || (st_q == ST_TURN_IN));
  assign pkt_end  = in_pkt && (!DIR || (is_cmd && (rx_ev == RXEV_INACTIVE)));

  usb_crc_byte u_crc (
    .data_i  (ulpi_din),
    .crc5_i  (crc5_q),
    .crc16_i (crc16_q),
    .crc5_o  (crc5_nxt),
    .crc16_o (crc16_nxt)
  );

  // Packet check, evaluated against the state accumulated up to the end edge.
  always_comb begin
    pid_bad = (pid_q[7:4] != ~pid_q[3:0]);
    len_bad = 1'b0;
    crc_bad = 1'b0;
    if (is_token(pid_q[3:0])) begin
      len_bad = (cnt_q != CNT_W'(3));
      crc_bad = (crc5_q != CRC5_RESIDUE);
    end else if (is_data(pid_q[3:0])) begin
      len_bad = (cnt_q < CNT_W'(3)) || (cnt_q > MAX_CNT);
      crc_bad = (crc16_q != CRC16_RESIDUE);
    end else if (is_hshk(pid_q[3:0])) begin
      len_bad = (cnt_q != CNT_W'(1));
    end
    if (rxerr_q)      err_c = ERR_RXERR;
    else if (ovf_q)   err_c = ERR_OVF;
    else if (pid_bad) err_c = ERR_PID;
    else if (len_bad) err_c = ERR_LEN;
    else if (crc_bad) err_c = ERR_CRC;
    else              err_c = ERR_NONE;
  end

  always_comb begin
    st_d       = st_q;
    hold_d     = hold_q;
    hold_vld_d = hold_vld_q;
    hold_sop_d = hold_sop_q;
    cnt_d      = cnt_q;
    pid_d      = pid_q;
    b1_d       = b1_q;
    b2_d       = b2_q;
    crc5_d     = crc5_q;
    crc16_d    = crc16_q;
    rxerr_d    = rxerr_q;
    ovf_d      = ovf_q;
    rx_valid_d = 1'b0;
    rx_data_d  = rx_data_q;
    rx_sop_d   = 1'b0;
    rx_eop_d   = 1'b0;
    pkt_done_d = 1'b0;
    pkt_ok_d   = pkt_ok_q;
    pkt_err_d  = pkt_err_q;
    pkt_pid_d  = pkt_pid_q;
    pkt_len_d  = pkt_len_q;
    tok_d      = tok_q;
    ls_d       = ls_q;
    vbus_d     = vbus_q;

    case (st_q)
      ST_IDLE:     if (DIR) st_d = ST_TURN_IN;
      ST_TURN_IN:  st_d = take_pid ? ST_RX_PID : (DIR ? ST_RX_CMD : ST_IDLE);
      ST_RX_CMD: begin
        if (!DIR)          st_d = ST_TURN_OUT;
        else if (take_pid) st_d = ST_RX_PID;
      end
      ST_RX_PID,
      ST_RX_BODY: begin
        if (!DIR)         st_d = ST_TURN_OUT;
        else if (pkt_end) st_d = ST_RX_CMD;
        else              st_d = ST_RX_BODY;
      end
      ST_TURN_OUT: st_d = DIR ? ST_TURN_IN : ST_IDLE;
      default:     st_d = ST_IDLE;
    endcase

    if (is_cmd && ((st_q == ST_RX_CMD) || in_pkt)) begin
      ls_d   = ulpi_din[RXCMD_LS_LSB +: 2];
      vbus_d = ulpi_din[RXCMD_VBUS_LSB +: 2];
    end

    if (take_pid) begin
      pid_d      = ulpi_din;
      hold_d     = ulpi_din;
      hold_vld_d = 1'b1;
      hold_sop_d = 1'b1;
      cnt_d      = CNT_W'(1);
      b1_d       = '0;
      b2_d       = '0;
      crc5_d     = CRC5_INIT;
      crc16_d    = CRC16_INIT;
      rxerr_d    = 1'b0;
      ovf_d      = 1'b0;
    end

    if (in_pkt && is_cmd && (rx_ev == RXEV_ERROR)) rxerr_d = 1'b1;

    // Each accepted byte pushes the previously held byte out; bytes past the limit are dropped.
    if (in_pkt && is_byte) begin
      cnt_d = (cnt_q == CNT_SAT) ? cnt_q : cnt_q + CNT_W'(1);
      if (cnt_q >= MAX_CNT) begin
        ovf_d = 1'b1;
      end else begin
        rx_valid_d = hold_vld_q;
        rx_data_d  = hold_q;
        rx_sop_d   = hold_sop_q;
        hold_d     = ulpi_din;
        hold_sop_d = 1'b0;
        crc5_d     = crc5_nxt;
        crc16_d    = crc16_nxt;
        if (cnt_q == CNT_W'(1)) b1_d = ulpi_din;
        if (cnt_q == CNT_W'(2)) b2_d = ulpi_din[2:0];
      end
    end

    if (pkt_end) begin
      rx_valid_d = hold_vld_q;
      rx_data_d  = hold_q;
      rx_sop_d   = hold_sop_q;
      rx_eop_d   = hold_vld_q;
      hold_vld_d = 1'b0;
      pkt_done_d = 1'b1;
      pkt_err_d  = err_c;
      pkt_ok_d   = (err_c == ERR_NONE);
      pkt_pid_d  = pid_q[3:0];
      pkt_len_d  = cnt_q;
      if (is_token(pid_q[3:0])) tok_d = {b2_q, b1_q};
    end
  end

  always_ff @(posedge CLKOUT) begin
    if (!RESET) begin
      st_q       <= ST_IDLE;
      hold_q     <= '0;
      hold_vld_q <= 1'b0;
      hold_sop_q <= 1'b0;
      cnt_q      <= '0;
      pid_q      <= '0;
      b1_q       <= '0;
      b2_q       <= '0;
      crc5_q     <= CRC5_INIT;
      crc16_q    <= CRC16_INIT;
      rxerr_q    <= 1'b0;
      ovf_q      <= 1'b0;
      rx_valid_q <= 1'b0;
      rx_data_q  <= '0;
      rx_sop_q   <= 1'b0;
      rx_eop_q   <= 1'b0;
      pkt_done_q <= 1'b0;
      pkt_ok_q   <= 1'b0;
      pkt_err_q  <= '0;
      pkt_pid_q  <= '0;
      pkt_len_q  <= '0;
      tok_q      <= '0;
      ls_q       <= '0;
      vbus_q     <= '0;
    end else begin
      st_q       <= st_d;
      hold_q     <= hold_d;
      hold_vld_q <= hold_vld_d;
      hold_sop_q <= hold_sop_d;
      cnt_q      <= cnt_d;
      pid_q      <= pid_d;
      b1_q       <= b1_d;
      b2_q       <= b2_d;
      crc5_q     <= crc5_d;
      crc16_q    <= crc16_d;
      rxerr_q    <= rxerr_d;
      ovf_q      <= ovf_d;
      rx_valid_q <= rx_valid_d;
      rx_data_q  <= rx_data_d;
      rx_sop_q   <= rx_sop_d;
      rx_eop_q   <= rx_eop_d;
      pkt_done_q <= pkt_done_d;
      pkt_ok_q   <= pkt_ok_d;
      pkt_err_q  <= pkt_err_d;
      pkt_pid_q  <= pkt_pid_d;
      pkt_len_q  <= pkt_len_d;
      tok_q      <= tok_d;
      ls_q       <= ls_d;
      vbus_q     <= vbus_d;
    end
  end

  assign rx_valid   = rx_valid_q;
  assign rx_data    = rx_data_q;
  assign rx_sop     = rx_sop_q;
  assign rx_eop     = rx_eop_q;
  assign pkt_done   = pkt_done_q;
  assign pkt_ok     = pkt_ok_q;
  assign pkt_err    = pkt_err_q;
  assign pkt_pid    = pkt_pid_q;
  assign pkt_len    = pkt_len_q;
  assign tok_field  = tok_q;
  assign linestate  = ls_q;
  assign vbus_state = vbus_q;

endmodule

// File: tb/tb_ulpi_rx_packetizer.sv
// Scoreboard bench for ulpi_rx_packetizer: expected beats and packet status are queued
// as each packet is driven and compared when the DUT emits them.
module tb_ulpi_rx_packetizer;

  localparam int unsigned MAX_BYTES = 67;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        dir, nxt;
  logic [7:0]  din;
  logic        rx_valid, rx_sop, rx_eop, pkt_done, pkt_ok;
  logic [7:0]  rx_data;
  logic [2:0]  pkt_err;
  logic [3:0]  pkt_pid;
  logic [6:0]  pkt_len;
  logic [10:0] tok_field;
  logic [1:0]  linestate, vbus_state;

  typedef logic [7:0] byte_q_t[$];
  typedef struct {
    logic [7:0] data;
    logic       sop;
    logic       eop;
  } beat_t;
  typedef struct {
    logic       ok;
    logic [2:0] err;
    logic [3:0] pid;
    logic [6:0] len;
    logic       chk_tok;
  } stat_t;

  beat_t beat_q[$];
  stat_t stat_q[$];
  beat_t exp_beat;
  stat_t exp_stat;

  int n_cmp = 0;
  int n_err = 0;
  int n_beats = 0;
  int n_done = 0;

  ulpi_rx_packetizer #(.MAX_BYTES(MAX_BYTES)) dut (
    .CLKOUT     (clk),
    .RESET      (rst_n),
    .DIR        (dir),
    .NXT        (nxt),
    .ulpi_din   (din),
    .rx_valid   (rx_valid),
    .rx_data    (rx_data),
    .rx_sop     (rx_sop),
    .rx_eop     (rx_eop),
    .pkt_done   (pkt_done),
    .pkt_ok     (pkt_ok),
    .pkt_err    (pkt_err),
    .pkt_pid    (pkt_pid),
    .pkt_len    (pkt_len),
    .tok_field  (tok_field),
    .linestate  (linestate),
    .vbus_state (vbus_state)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  task automatic bus(input logic d, input logic n, input logic [7:0] b);
    dir = d;
    nxt = n;
    din = b;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset_outs(input string tag);
    chk({tag, "_rx_valid"}, 32'(rx_valid), 0);
    chk({tag, "_rx_data"}, 32'(rx_data), 0);
    chk({tag, "_rx_sop"}, 32'(rx_sop), 0);
    chk({tag, "_rx_eop"}, 32'(rx_eop), 0);
    chk({tag, "_pkt_done"}, 32'(pkt_done), 0);
    chk({tag, "_pkt_ok"}, 32'(pkt_ok), 0);
    chk({tag, "_pkt_err"}, 32'(pkt_err), 0);
    chk({tag, "_pkt_pid"}, 32'(pkt_pid), 0);
    chk({tag, "_pkt_len"}, 32'(pkt_len), 0);
    chk({tag, "_tok_field"}, 32'(tok_field), 0);
    chk({tag, "_linestate"}, 32'(linestate), 0);
    chk({tag, "_vbus_state"}, 32'(vbus_state), 0);
  endtask

  // Drive one received packet; err_at >= 0 inserts an RxError RXCMD before that byte.
  task automatic run_pkt(input byte_q_t b, input bit dir_end, input int err_at, input bit b2b,
                         input logic [2:0] eerr, input bit chk_tok);
    beat_t bt;
    stat_t st;
    int    n_out;
    n_out = (b.size() > int'(MAX_BYTES)) ? int'(MAX_BYTES) : b.size();
    for (int i = 0; i < n_out; i++) begin
      bt.data = b[i];
      bt.sop  = (i == 0);
      bt.eop  = (i == n_out - 1);
      beat_q.push_back(bt);
    end
    st.err     = eerr;
    st.ok      = (eerr == 3'd0);
    st.pid     = b[0][3:0];
    st.len     = (b.size() > 127) ? 7'd127 : 7'(b.size());
    st.chk_tok = chk_tok;
    stat_q.push_back(st);

    bus(1'b1, 1'b0, 8'h00);
    bus(1'b1, 1'b0, 8'h10);
    for (int i = 0; i < b.size(); i++) begin
      if (i == err_at) bus(1'b1, 1'b0, 8'h30);
      bus(1'b1, 1'b1, b[i]);
    end
    if (dir_end) begin
      bus(1'b0, 1'b0, 8'h00);
      if (!b2b) bus(1'b0, 1'b0, 8'h00);
    end else begin
      bus(1'b1, 1'b0, 8'h00);
      bus(1'b0, 1'b0, 8'h00);
      bus(1'b0, 1'b0, 8'h00);
    end
  endtask

  // Output monitor: every beat and every status pulse is matched against the queues.
  always @(negedge clk) begin
    if (rx_valid) begin
      n_beats++;
      if (beat_q.size() == 0) begin
        chk("unexpected_beat", 32'(rx_data), 32'hFFFF_FFFF);
      end else begin
        exp_beat = beat_q.pop_front();
        chk("rx_data", 32'(rx_data), 32'(exp_beat.data));
        chk("rx_sop", 32'(rx_sop), 32'(exp_beat.sop));
        chk("rx_eop", 32'(rx_eop), 32'(exp_beat.eop));
      end
    end
    if (pkt_done) begin
      n_done++;
      if (stat_q.size() == 0) begin
        chk("unexpected_pkt_done", 32'(pkt_done), 0);
      end else begin
        exp_stat = stat_q.pop_front();
        chk("pkt_ok", 32'(pkt_ok), 32'(exp_stat.ok));
        chk("pkt_err", 32'(pkt_err), 32'(exp_stat.err));
        chk("pkt_pid", 32'(pkt_pid), 32'(exp_stat.pid));
        chk("pkt_len", 32'(pkt_len), 32'(exp_stat.len));
        if (exp_stat.chk_tok) chk("tok_field", 32'(tok_field), 0);
      end
    end
  end

  initial begin
    #1_000_000;
    n_err++;
    $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    byte_q_t tok, dat, bad, ovf;
    int      done_mark;
    int      beat_mark;

    rst_n = 1'b0;
    dir = 1'b0; nxt = 1'b0; din = 8'h00;
    repeat (3) bus(1'b0, 1'b0, 8'h00);
    chk_reset_outs("init");
    rst_n = 1'b1;
    bus(1'b0, 1'b0, 8'h00);

    tok = '{8'h2D, 8'h00, 8'h10};
    run_pkt(tok, 1'b0, -1, 1'b0, 3'd0, 1'b1);

    dat = '{8'hC3, 8'h80, 8'h06, 8'h00, 8'h01, 8'h00, 8'h00, 8'h40, 8'h00, 8'hDD, 8'h94};
    run_pkt(dat, 1'b1, -1, 1'b1, 3'd0, 1'b0);
    bad = '{8'h69, 8'h00, 8'h10};
    run_pkt(bad, 1'b0, -1, 1'b0, 3'd0, 1'b1);

    bad = dat;
    bad[2] = 8'h07;
    run_pkt(bad, 1'b1, -1, 1'b0, 3'd2, 1'b0);

    bad = '{8'h2E, 8'h00, 8'h10};
    run_pkt(bad, 1'b0, -1, 1'b0, 3'd1, 1'b0);

    bad = '{8'h5A};
    run_pkt(bad, 1'b0, -1, 1'b0, 3'd0, 1'b0);

    run_pkt(tok, 1'b0, 1, 1'b0, 3'd4, 1'b0);

    bad = '{8'h4B, 8'h00, 8'h00};
    run_pkt(bad, 1'b1, -1, 1'b0, 3'd0, 1'b0);

    ovf = {};
    ovf.push_back(8'hC3);
    for (int i = 1; i < 70; i++) ovf.push_back(8'(i));
    beat_mark = n_beats;
    run_pkt(ovf, 1'b0, -1, 1'b0, 3'd5, 1'b0);
    chk("ovf_beats", 32'(n_beats - beat_mark), 32'(MAX_BYTES));

    // RXCMD with no packet: only line/vbus state changes.
    done_mark = n_done;
    bus(1'b1, 1'b0, 8'h00);
    bus(1'b1, 1'b0, 8'h0D);
    bus(1'b1, 1'b0, 8'h0D);
    chk("linestate", 32'(linestate), 1);
    chk("vbus_state", 32'(vbus_state), 3);
    bus(1'b0, 1'b0, 8'h00);
    bus(1'b0, 1'b0, 8'h00);
    chk("idle_no_done", 32'(n_done - done_mark), 0);

    // Reset in the middle of a data packet: the held byte is lost, no status.
    for (int i = 0; i < 3; i++) begin
      exp_beat.data = dat[i];
      exp_beat.sop  = (i == 0);
      exp_beat.eop  = 1'b0;
      beat_q.push_back(exp_beat);
    end
    done_mark = n_done;
    bus(1'b1, 1'b0, 8'h00);
    bus(1'b1, 1'b0, 8'h10);
    for (int i = 0; i < 4; i++) bus(1'b1, 1'b1, dat[i]);
    rst_n = 1'b0;
    bus(1'b0, 1'b0, 8'h00);
    chk_reset_outs("midrst");
    rst_n = 1'b1;
    bus(1'b0, 1'b0, 8'h00);
    bus(1'b0, 1'b0, 8'h00);
    chk("midrst_no_done", 32'(n_done - done_mark), 0);

    run_pkt(tok, 1'b0, -1, 1'b0, 3'd0, 1'b1);

    repeat (4) bus(1'b0, 1'b0, 8'h00);
    chk("beats_left", 32'(beat_q.size()), 0);
    chk("status_left", 32'(stat_q.size()), 0);
    chk("total_done", 32'(n_done), 10);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
